// File: rtl/weight_mem_burst.sv
// Weight memory with a preload write port and a burst read engine that streams
// consecutive words through a LATENCY-deep {valid, data, last, err} pipeline.
module weight_mem_burst #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 8,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    output logic              resp_err,
    output logic              busy
);

    generate
        if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
            $error("weight_mem_burst: LATENCY must be in 1..4");
        end
    endgenerate

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   remain_q, remain_d;

    logic               issue;
    logic               issue_last;
    logic [ADDR_W-1:0]  issue_addr;
    logic               rd_in_range;
    logic [DATA_W-1:0]  rd_word;
    logic               wr_in_range;

    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] last_q, last_d;
    logic [LATENCY-1:0] err_q, err_d;
    logic [DATA_W-1:0]  data_q [LATENCY];
    logic [DATA_W-1:0]  data_d [LATENCY];

    assign req_ready = (state_q == IDLE);

    // Beat 0 issues in the accept cycle; BURST issues the remaining req_len beats.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        issue_addr = addr_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    issue      = 1'b1;
                    issue_addr = req_addr;
                    issue_last = (req_len == '0);
                    if (req_len != '0) begin
                        addr_d   = req_addr + ADDR_W'(1);
                        remain_d = req_len;
                        state_d  = BURST;
                    end
                end
            end
            BURST: begin
                issue      = 1'b1;
                issue_addr = addr_q;
                issue_last = (remain_q == LEN_W'(1));
                addr_d     = addr_q + ADDR_W'(1);
                remain_d   = remain_q - LEN_W'(1);
                if (remain_q == LEN_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
        end
    end

    // Combinational read sees the pre-edge contents, giving read-before-write.
    assign rd_in_range = ({1'b0, issue_addr} < DEPTH_EXT);
    assign rd_word     = rd_in_range ? mem_q[issue_addr[IDX_W-1:0]] : '0;
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);

    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem_q[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // Payload only advances alongside a valid beat so outputs hold between beats.
    always_comb begin
        vld_d[0]  = issue;
        data_d[0] = issue ? rd_word : data_q[0];
        last_d[0] = issue ? issue_last : last_q[0];
        err_d[0]  = issue ? !rd_in_range : err_q[0];
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            data_d[i] = vld_q[i-1] ? data_q[i-1] : data_q[i];
            last_d[i] = vld_q[i-1] ? last_q[i-1] : last_q[i];
            err_d[i]  = vld_q[i-1] ? err_q[i-1]  : err_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            last_q <= '0;
            err_q  <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            last_q <= last_d;
            err_q  <= err_d;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign resp_valid = vld_q[LATENCY-1];
    assign resp_data  = data_q[LATENCY-1];
    assign resp_last  = last_q[LATENCY-1];
    assign resp_err   = err_q[LATENCY-1];
    assign busy       = (state_q == BURST) || (|vld_q);

endmodule

// File: doc/weight_mem_burst.md
Name: weight_mem_burst

Overview:
- Parametrised weight memory with a burst read engine, a preload write port and a configurable read pipeline latency.
- One request address plus a length yields a stream of consecutive weight beats, one per cycle, with a last-beat marker.
- Feeds the stream-based conv/dense engines.
- Response channel has no backpressure: consumers must sink every beat.

Parameters:
- DATA_W, 8: width of one weight word.
- DEPTH, 1024: number of words stored.
- ADDR_W, 32: width of request/write addresses.
- LEN_W, 8: width of burst length field.
- LATENCY, 1: read latency in cycles. Legal range 1..4; any other value is an elaboration error.

Ports:
- clk  in  1: rising-edge clock.
- rst_n  in  1: asynchronous active-low reset.
- req_valid  in  1: burst request present.
- req_ready  out  1: engine can accept a request this cycle.
- req_addr  in  ADDR_W: first word address of burst.
- req_len  in  LEN_W: beats minus one (0 = single beat).
- wr_en  in  1: write strobe for preload.
- wr_addr  in  ADDR_W: write address.
- wr_data  in  DATA_W: write data.
- resp_valid  out  1: response beat valid.
- resp_data  out  DATA_W: read word.
- resp_last  out  1: final beat of the burst.
- resp_err  out  1: this beat addressed a location >= DEPTH.
- busy  out  1: burst in progress or any pipeline stage holding a valid beat.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state forced to IDLE; all pipeline valid bits cleared.
  - resp_valid=0, resp_data=0, resp_last=0, resp_err=0, busy=0.
  - Memory contents are not cleared.
  - Reset mid-burst aborts the burst; no further beats are emitted after deassertion.
- States: IDLE, BURST.
  - req_ready = (state==IDLE).
  - Handshake: the request is accepted in cycle C0 when req_valid && req_ready.
  - IDLE:
    - On accept, beat 0 reads req_addr in C0.
    - If req_len==0, stay in IDLE. Otherwise latch addr=req_addr+1 and remain=req_len, then go to BURST.
  - BURST:
    - Each cycle read addr, then addr+=1 and remain-=1.
    - On the cycle that issues beat req_len, return to IDLE.
    - req_ready is low throughout BURST. A new request is accepted no earlier than cycle C0+req_len+1.
  - Single-beat requests may be accepted every cycle, giving full throughput.
- Timing: beat k (0..req_len) has resp_valid=1 in cycle C0+k+LATENCY. Data is registered and carried through a LATENCY-deep shift pipeline of {valid, data, last, err}.
- resp_last=1 only on beat req_len. resp_data, resp_err and resp_last are qualified by resp_valid; they are held at their last values when resp_valid=0.
- Address arithmetic is modulo 2^ADDR_W.
  - Any beat whose address >= DEPTH returns resp_data=0 and resp_err=1.
  - Such a beat never indexes the array. The burst continues normally.
- Writes:
  - Applied on the clock edge when wr_en=1 and wr_addr<DEPTH. Out-of-range writes are dropped silently.
  - Writes are independent of the burst engine and always accepted.
- Same-cycle read and write to the same address: the read returns the old data (read-before-write).
- Write followed by read one cycle later returns the new data.
- busy = (state==BURST) OR any pipeline valid bit. busy is 0 exactly when no beat remains to be emitted.

Test Plan:
- Preload mem[i]=i&0xFF for i=0..15. Single request addr=5, len=0, LATENCY=1 -> one beat in cycle C0+1: data=0x05, last=1, err=0.
- Burst addr=2, len=3, LATENCY=3:
  - beats data=2,3,4,5 in cycles C0+3..C0+6; last only on data=5.
  - req_ready low in C0+1..C0+3.
  - busy drops after C0+6.
- Back-to-back single requests addr=7,8,9 on consecutive cycles, LATENCY=2 -> resp_valid high 3 consecutive cycles with data 7,8,9; req_ready stays 1.
- Boundary, DEPTH=1024: burst addr=1022, len=3 -> beats mem[1022], mem[1023], then 0 with err=1, then 0 with err=1 and last=1.
- Collision: write addr=4 data=0xAA in the same cycle a single read of addr=4 issues -> old value 0x04 returned. A read issued next cycle -> 0xAA.
- Reset mid-burst: addr=0, len=9, assert rst_n low after beat 3 is emitted.
  - During reset and after release: resp_valid=0, busy=0, req_ready=1.
  - A new request addr=0, len=0 after release returns 0x00 with last=1.
